// File: rtl/retro_memory_pkg.sv
// Shared constants and command decode for the RetroMemoryPort target.
package retro_memory_pkg;

    localparam int MaxReadLatency = 8;
    localparam int MaxWaitStates  = 15;

    typedef enum logic [1:0] {
        CmdIdle,
        CmdRead,
        CmdWrite
    } mem_cmd_e;

    // An all-zero access mask means no command regardless of Write.
    function automatic mem_cmd_e decode_cmd(input logic any_access, input logic write);
        if (!any_access) begin
            return CmdIdle;
        end
        return write ? CmdWrite : CmdRead;
    endfunction

endpackage

// File: rtl/retro_memory_target_pipeline.sv
// Fixed-depth shift register of {valid, data} carrying read responses in accept order.
module retro_read_pipeline #(
    parameter int Depth = 1,
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    output logic             head_valid,
    output logic [Width-1:0] head_data
);

    logic [Depth-1:0] valid;
    logic [Width-1:0] data [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < Depth; i++) begin
                data[i] <= '0;
            end
        end else begin
            valid[0] <= push;
            data[0]  <= push_data;
            for (int i = 1; i < Depth; i++) begin
                valid[i] <= valid[i-1];
                data[i]  <= data[i-1];
            end
        end
    end

    assign head_valid = valid[Depth-1];
    assign head_data  = data[Depth-1];

endmodule

// File: rtl/retro_memory_target.sv
// Responder end of RetroMemoryPort: word storage, accept logic, wait states and
// an outstanding-read limit in front of a fixed-latency in-order read pipeline.
module retro_memory_target
    import retro_memory_pkg::*;
#(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 1,
    parameter int MemWords        = 2 ** AddressBusWidth,
    parameter int ReadLatency     = 1,
    parameter int WaitStates      = 0,
    parameter int MaxOutstanding  = ReadLatency
) (
    input  logic                         Clk,
    input  logic                         nReset,
    input  logic [AddressBusWidth-1:0]   Address,
    input  logic [8*DataBusWidth-1:0]    Din,
    output logic [8*DataBusWidth-1:0]    Dout,
    input  logic [8*DataBusWidth-1:0]    Access,
    input  logic                         Write,
    output logic                         Ready,
    output logic                         DataReady
);

    localparam int DataW     = 8 * DataBusWidth;
    localparam int MemIdxW   = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int WaitW     = $clog2(MaxWaitStates + 1);
    localparam int InFlightW = $clog2(MaxReadLatency + 1);

    if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
        $error("ReadLatency must be 1..%0d", MaxReadLatency);
    end
    if (WaitStates < 0 || WaitStates > MaxWaitStates) begin : g_bad_wait
        $error("WaitStates must be 0..%0d", MaxWaitStates);
    end
    if (MaxOutstanding < 1 || MaxOutstanding > ReadLatency) begin : g_bad_outstanding
        $error("MaxOutstanding must be 1..ReadLatency");
    end
    if (MemWords < 1 || MemWords > 2 ** AddressBusWidth) begin : g_bad_depth
        $error("MemWords must be 1..2**AddressBusWidth");
    end

    logic                 started;
    logic [WaitW-1:0]     wait_cnt;
    logic [InFlightW-1:0] in_flight;
    logic [DataW-1:0]     mem [MemWords];

    mem_cmd_e             cmd;
    logic                 accept;
    logic                 rd_push;
    logic                 in_range;
    logic [MemIdxW-1:0]   mem_idx;
    logic [DataW-1:0]     rd_word;
    logic                 head_valid;
    logic [DataW-1:0]     head_data;

    assign Ready    = started && (wait_cnt == '0) && (in_flight < InFlightW'(MaxOutstanding));
    assign cmd      = decode_cmd(|Access, Write);
    assign accept   = Ready && (cmd != CmdIdle);
    assign rd_push  = accept && (cmd == CmdRead);
    assign in_range = {1'b0, Address} < (AddressBusWidth + 1)'(MemWords);
    assign mem_idx  = Address[MemIdxW-1:0];
    // Out-of-range reads still travel the pipeline so the strobe timing is unchanged.
    assign rd_word  = in_range ? (mem[mem_idx] & Access) : '0;

    always_ff @(posedge Clk) begin
        if (accept && (cmd == CmdWrite) && in_range) begin
            mem[mem_idx] <= (mem[mem_idx] & ~Access) | (Din & Access);
        end
    end

    retro_read_pipeline #(
        .Depth (ReadLatency),
        .Width (DataW)
    ) u_read_pipeline (
        .clk        (Clk),
        .rst_n      (nReset),
        .push       (rd_push),
        .push_data  (rd_word),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            started   <= 1'b0;
            wait_cnt  <= '0;
            in_flight <= '0;
            DataReady <= 1'b0;
            Dout      <= '0;
        end else begin
            started <= 1'b1;

            if (accept) begin
                wait_cnt <= WaitW'(WaitStates);
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WaitW'(1);
            end

            // A read retiring at the same edge a new read enters leaves the count unchanged.
            case ({rd_push, head_valid})
                2'b10:   in_flight <= in_flight + InFlightW'(1);
                2'b01:   in_flight <= in_flight - InFlightW'(1);
                default: in_flight <= in_flight;
            endcase

            DataReady <= head_valid;
            if (head_valid) begin
                Dout <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_retro_memory_target.sv
// Bench for retro_memory_target: three parameterisations checked against a queue-based model.
module tb_retro_memory_target;

    localparam int RL_P [3] = '{1, 4, 3};
    localparam int WS_P [3] = '{0, 0, 3};
    localparam int MO_P [3] = '{1, 2, 3};
    localparam int MW_P [3] = '{256, 4096, 4096};

    typedef struct { int k; int due; logic [7:0] data; } rd_t;
    typedef struct { int k; int edge_no; logic [7:0] data; } sb_t;

    logic        Clk = 1'b0;
    logic [2:0]  n_reset = 3'b111;
    logic [15:0] addr   [3];
    logic [7:0]  din    [3];
    logic [7:0]  access [3];
    logic [7:0]  dout   [3];
    logic [2:0]  wr;
    logic [2:0]  ready;
    logic [2:0]  dr;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;

    rd_t        rq [$];
    sb_t        sq [$];
    logic [7:0] mem_m [int];
    bit         started_m  [3];
    bit         acc_m      [3];
    bit         dr_m       [3];
    int         wait_m     [3];
    int         acc_edge_m [3];
    logic [7:0] dout_m     [3];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        retro_memory_target #(
            .AddressBusWidth (16),
            .DataBusWidth    (1),
            .MemWords        (MW_P[g]),
            .ReadLatency     (RL_P[g]),
            .WaitStates      (WS_P[g]),
            .MaxOutstanding  (MO_P[g])
        ) dut (
            .Clk       (Clk),
            .nReset    (n_reset[g]),
            .Address   (addr[g]),
            .Din       (din[g]),
            .Dout      (dout[g]),
            .Access    (access[g]),
            .Write     (wr[g]),
            .Ready     (ready[g]),
            .DataReady (dr[g])
        );

        always @(posedge Clk or negedge n_reset[g]) begin
            if (!n_reset[g]) model_reset(g);
            else model_step(g);
        end
    end

    function automatic int inflight(input int k);
        int n = 0;
        foreach (rq[i]) if (rq[i].k == k) n++;
        return n;
    endfunction

    function automatic bit exp_ready(input int k);
        return started_m[k] && (wait_m[k] == 0) && (inflight(k) < MO_P[k]);
    endfunction

    function automatic logic [7:0] mem_of(input int key);
        return mem_m.exists(key) ? mem_m[key] : 8'h00;
    endfunction

    task automatic model_reset(input int k);
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].k == k) rq.delete(i);
        started_m[k] = 1'b0;
        acc_m[k]     = 1'b0;
        dr_m[k]      = 1'b0;
        wait_m[k]    = 0;
        dout_m[k]    = 8'h00;
    endtask

    // One rising edge: decide acceptance from pre-edge state, retire a due read, then apply the command.
    task automatic model_step(input int k);
        bit         acc;
        int         key;
        bit         inr;
        logic [7:0] rd;
        acc = exp_ready(k) && (access[k] != 8'h00);
        acc_m[k] = acc;
        if (acc) acc_edge_m[k] = edge_n;
        dr_m[k] = 1'b0;
        for (int i = 0; i < rq.size(); i++) begin
            if (rq[i].k == k) begin
                if (rq[i].due == edge_n) begin
                    dr_m[k]   = 1'b1;
                    dout_m[k] = rq[i].data;
                    rq.delete(i);
                end
                break;
            end
        end
        if (acc) wait_m[k] = WS_P[k];
        else if (wait_m[k] > 0) wait_m[k]--;
        key = k * 65536 + int'(addr[k]);
        inr = int'(addr[k]) < MW_P[k];
        if (acc && wr[k] && inr) mem_m[key] = (mem_of(key) & ~access[k]) | (din[k] & access[k]);
        if (acc && !wr[k]) begin
            rd = inr ? (mem_of(key) & access[k]) : 8'h00;
            rq.push_back('{k, edge_n + RL_P[k], rd});
        end
        started_m[k] = 1'b1;
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ready[k] !== exp_ready(k)) begin
                    errors++;
                    $display("FAIL ready[%0d] edge %0d actual=%b expected=%b", k, edge_n, ready[k], exp_ready(k));
                end
                checks++;
                if (dr[k] !== dr_m[k]) begin
                    errors++;
                    $display("FAIL data_ready[%0d] edge %0d actual=%b expected=%b", k, edge_n, dr[k], dr_m[k]);
                end
                checks++;
                if (dout[k] !== dout_m[k]) begin
                    errors++;
                    $display("FAIL dout[%0d] edge %0d actual=%h expected=%h", k, edge_n, dout[k], dout_m[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) if (dr[k] === 1'b1) sq.push_back('{k, edge_n, dout[k]});
        edge_n++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Present a command and hold it until the target accepts it, bounded.
    task automatic cmd(input int k, input bit w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] m);
        int n = 0;
        @(negedge Clk);
        addr[k] = a; din[k] = d; access[k] = m; wr[k] = w;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!acc_m[k] && n < 60);
        checks++;
        if (!acc_m[k]) begin
            errors++;
            $display("FAIL cmd_accept inst %0d addr %h actual=not_accepted expected=accepted", k, a);
        end
    endtask

    task automatic idle(input int k);
        @(negedge Clk);
        access[k] = 8'h00;
    endtask

    task automatic get_strobe(input int k, output logic [7:0] d, output int e);
        int idx = -1;
        d = 8'hxx;
        e = -1;
        for (int n = 0; n < 40 && idx < 0; n++) begin
            @(negedge Clk); #1;
            foreach (sq[i]) if (idx < 0 && sq[i].k == k) idx = i;
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL strobe_timeout inst %0d actual=none expected=strobe", k);
        end else begin
            d = sq[idx].data;
            e = sq[idx].edge_no;
            sq.delete(idx);
        end
    endtask

    initial begin
        logic [7:0] d;
        int e, e0, e1, e2, s0, s1, s2, cnt;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; din[k] = '0; access[k] = '0;
        end
        wr = '0;
        #2 n_reset = 3'b000;
        chk_en = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", ready[k], 0);
            chk("rst_data_ready", dr[k], 0);
            chk("rst_dout", dout[k], 0);
        end
        repeat (2) @(negedge Clk);
        n_reset = 3'b111;
        #1 chk("start_ready_low", ready[0], 0);
        @(posedge Clk); #1 chk("start_ready_high", ready[0], 1);

        // Latency 1, no wait states: write then read next cycle
        cmd(0, 1'b1, 16'h0010, 8'hA5, 8'hFF);
        cmd(0, 1'b0, 16'h0010, 8'h00, 8'hFF);
        e0 = acc_edge_m[0];
        idle(0);
        get_strobe(0, d, e);
        chk("t1_data", d, 8'hA5);
        chk("t1_latency", e - e0, 1);

        // Partial access mask
        cmd(0, 1'b1, 16'h0020, 8'hFF, 8'hFF);
        cmd(0, 1'b1, 16'h0020, 8'h00, 8'h0F);
        cmd(0, 1'b0, 16'h0020, 8'h00, 8'hFF);
        idle(0);
        get_strobe(0, d, e);
        chk("mask_data", d, 8'hF0);

        // Out-of-range write discarded, read returns zero; word 0 untouched
        cmd(0, 1'b1, 16'h0000, 8'h3C, 8'hFF);
        cmd(0, 1'b1, 16'h0100, 8'h55, 8'hFF);
        cmd(0, 1'b0, 16'h0100, 8'h00, 8'hFF);
        cmd(0, 1'b0, 16'h0000, 8'h00, 8'hFF);
        idle(0);
        get_strobe(0, d, e);
        chk("oor_read_zero", d, 8'h00);
        get_strobe(0, d, e);
        chk("oor_word0_kept", d, 8'h3C);

        // Latency 4, two outstanding: third read waits for the first retirement
        cmd(1, 1'b1, 16'h0001, 8'h11, 8'hFF);
        cmd(1, 1'b1, 16'h0002, 8'h22, 8'hFF);
        cmd(1, 1'b1, 16'h0003, 8'h33, 8'hFF);
        cmd(1, 1'b0, 16'h0001, 8'h00, 8'hFF);
        e0 = acc_edge_m[1];
        cmd(1, 1'b0, 16'h0002, 8'h00, 8'hFF);
        e1 = acc_edge_m[1];
        chk("lim_ready_low", ready[1], 0);
        cmd(1, 1'b0, 16'h0003, 8'h00, 8'hFF);
        e2 = acc_edge_m[1];
        idle(1);
        get_strobe(1, d, s0);
        chk("lim_data0", d, 8'h11);
        get_strobe(1, d, s1);
        chk("lim_data1", d, 8'h22);
        get_strobe(1, d, s2);
        chk("lim_data2", d, 8'h33);
        chk("lim_accept_gap", e1 - e0, 1);
        chk("lim_third_accept", e2 - e0, 5);
        chk("lim_third_in_strobe_cycle", e2 - s0, 1);
        chk("lim_b2b_strobes", s1 - s0, 1);
        chk("lim_latency", s0 - e0, 4);
        chk("lim_third_latency", s2 - e2, 4);

        // Three wait states between held commands
        cmd(2, 1'b1, 16'h0030, 8'h77, 8'hFF);
        e0 = acc_edge_m[2];
        chk("ws_ready_low", ready[2], 0);
        cmd(2, 1'b0, 16'h0030, 8'h00, 8'hFF);
        e1 = acc_edge_m[2];
        idle(2);
        chk("ws_accept_gap", e1 - e0, 4);
        get_strobe(2, d, e);
        chk("ws_data", d, 8'h77);
        chk("ws_latency", e - e1, 3);

        // Reset one cycle after a read accept drops the read but keeps storage
        cmd(2, 1'b0, 16'h0030, 8'h00, 8'hFF);
        idle(2);
        @(posedge Clk); #2;
        n_reset[2] = 1'b0;
        #1;
        chk("mid_rst_ready", ready[2], 0);
        chk("mid_rst_data_ready", dr[2], 0);
        repeat (2) @(negedge Clk);
        n_reset[2] = 1'b1;
        #1 chk("mid_rst_release_ready_low", ready[2], 0);
        @(posedge Clk); #1 chk("mid_rst_ready_high", ready[2], 1);
        repeat (8) @(negedge Clk);
        #1;
        cnt = 0;
        foreach (sq[i]) if (sq[i].k == 2) cnt++;
        chk("mid_rst_no_strobe", cnt, 0);
        cmd(2, 1'b0, 16'h0030, 8'h00, 8'hFF);
        idle(2);
        get_strobe(2, d, e);
        chk("mid_rst_storage_kept", d, 8'h77);

        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
